// File: rtl/op_predecode_if.sv
// Handshake and payload bundle between fetch, the pre-decode stage and the main decoder.
interface op_predecode_if #(
  parameter int unsigned LANES     = 2,
  parameter int unsigned BUF_DEPTH = 2
);
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  logic                  flush_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [LANES-1:0]      in_lane_mask_i;
  logic [32*LANES-1:0]   in_inst_i;
  logic [32*LANES-1:0]   in_pc_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [LANES-1:0]      out_lane_mask_o;
  logic [64*LANES-1:0]   out_op_31_26_o;
  logic [16*LANES-1:0]   out_op_25_22_o;
  logic [4*LANES-1:0]    out_op_21_20_o;
  logic [32*LANES-1:0]   out_op_19_15_o;
  logic [32*LANES-1:0]   out_rd_o;
  logic [32*LANES-1:0]   out_rj_o;
  logic [32*LANES-1:0]   out_rk_o;
  logic [32*LANES-1:0]   out_inst_o;
  logic [32*LANES-1:0]   out_pc_o;
  logic [CW-1:0]         count_o;

  // Producer/consumer side (fetch + decoder, or a bench).
  modport master (
    output flush_i, in_valid_i, in_lane_mask_i, in_inst_i, in_pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_lane_mask_o, out_op_31_26_o, out_op_25_22_o,
           out_op_21_20_o, out_op_19_15_o, out_rd_o, out_rj_o, out_rk_o,
           out_inst_o, out_pc_o, count_o
  );

  // Stage side.
  modport slave (
    input  flush_i, in_valid_i, in_lane_mask_i, in_inst_i, in_pc_i, out_ready_i,
    output in_ready_o, out_valid_o, out_lane_mask_o, out_op_31_26_o, out_op_25_22_o,
           out_op_21_20_o, out_op_19_15_o, out_rd_o, out_rj_o, out_rk_o,
           out_inst_o, out_pc_o, count_o
  );
endinterface

// File: rtl/op_predecode_stage.sv
// Multi-lane LoongArch pre-decode: expands opcode slices and register fields to one-hot
// vectors and queues the results in a small FIFO with valid/ready on both sides.
module op_predecode_stage #(
  parameter int unsigned LANES     = 2,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  op_predecode_if.slave  bus
);
  localparam int unsigned PW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(BUF_DEPTH + 1);
  localparam int unsigned W64 = 64 * LANES;
  localparam int unsigned W16 = 16 * LANES;
  localparam int unsigned W4  = 4 * LANES;
  localparam int unsigned W32 = 32 * LANES;

  logic [W64-1:0]   dec_op_31_26;
  logic [W16-1:0]   dec_op_25_22;
  logic [W4-1:0]    dec_op_21_20;
  logic [W32-1:0]   dec_op_19_15;
  logic [W32-1:0]   dec_rd;
  logic [W32-1:0]   dec_rj;
  logic [W32-1:0]   dec_rk;
  logic [W32-1:0]   dec_inst;
  logic [W32-1:0]   dec_pc;
  logic [31:0]      lane_inst;

  // Per-lane one-hot expansion; masked-off lanes contribute all zeros.
  always_comb begin
    dec_op_31_26 = '0;
    dec_op_25_22 = '0;
    dec_op_21_20 = '0;
    dec_op_19_15 = '0;
    dec_rd       = '0;
    dec_rj       = '0;
    dec_rk       = '0;
    dec_inst     = '0;
    dec_pc       = '0;
    lane_inst    = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (bus.in_lane_mask_i[l]) begin
        lane_inst                = bus.in_inst_i[32*l +: 32];
        dec_op_31_26[64*l +: 64] = 64'd1 << lane_inst[31:26];
        dec_op_25_22[16*l +: 16] = 16'd1 << lane_inst[25:22];
        dec_op_21_20[4*l +: 4]   = 4'd1 << lane_inst[21:20];
        dec_op_19_15[32*l +: 32] = 32'd1 << lane_inst[19:15];
        dec_rd[32*l +: 32]       = 32'd1 << lane_inst[4:0];
        dec_rj[32*l +: 32]       = 32'd1 << lane_inst[9:5];
        dec_rk[32*l +: 32]       = 32'd1 << lane_inst[14:10];
        dec_inst[32*l +: 32]     = lane_inst;
        dec_pc[32*l +: 32]       = bus.in_pc_i[32*l +: 32];
      end
    end
  end

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          head_valid;
  logic          not_full;
  logic          accept;
  logic          wr_en;
  logic          pop;

  assign head_valid = (count_q != '0);
  assign not_full   = (count_q != CW'(BUF_DEPTH));
  assign accept     = bus.in_valid_i & not_full & ~bus.flush_i;
  // An empty-mask beat completes the handshake but occupies no slot.
  assign wr_en      = accept & (|bus.in_lane_mask_i);
  assign pop        = head_valid & bus.out_ready_i & ~bus.flush_i;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.flush_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_en, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  logic [LANES-1:0] mem_mask     [BUF_DEPTH];
  logic [W64-1:0]   mem_op_31_26 [BUF_DEPTH];
  logic [W16-1:0]   mem_op_25_22 [BUF_DEPTH];
  logic [W4-1:0]    mem_op_21_20 [BUF_DEPTH];
  logic [W32-1:0]   mem_op_19_15 [BUF_DEPTH];
  logic [W32-1:0]   mem_rd       [BUF_DEPTH];
  logic [W32-1:0]   mem_rj       [BUF_DEPTH];
  logic [W32-1:0]   mem_rk       [BUF_DEPTH];
  logic [W32-1:0]   mem_inst     [BUF_DEPTH];
  logic [W32-1:0]   mem_pc       [BUF_DEPTH];

  // Payload storage needs no reset: every output is gated by head_valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_mask[wr_ptr_q]     <= bus.in_lane_mask_i;
      mem_op_31_26[wr_ptr_q] <= dec_op_31_26;
      mem_op_25_22[wr_ptr_q] <= dec_op_25_22;
      mem_op_21_20[wr_ptr_q] <= dec_op_21_20;
      mem_op_19_15[wr_ptr_q] <= dec_op_19_15;
      mem_rd[wr_ptr_q]       <= dec_rd;
      mem_rj[wr_ptr_q]       <= dec_rj;
      mem_rk[wr_ptr_q]       <= dec_rk;
      mem_inst[wr_ptr_q]     <= dec_inst;
      mem_pc[wr_ptr_q]       <= dec_pc;
    end
  end

  assign bus.in_ready_o      = not_full;
  assign bus.out_valid_o     = head_valid;
  assign bus.count_o         = count_q;
  assign bus.out_lane_mask_o = head_valid ? mem_mask[rd_ptr_q]     : '0;
  assign bus.out_op_31_26_o  = head_valid ? mem_op_31_26[rd_ptr_q] : '0;
  assign bus.out_op_25_22_o  = head_valid ? mem_op_25_22[rd_ptr_q] : '0;
  assign bus.out_op_21_20_o  = head_valid ? mem_op_21_20[rd_ptr_q] : '0;
  assign bus.out_op_19_15_o  = head_valid ? mem_op_19_15[rd_ptr_q] : '0;
  assign bus.out_rd_o        = head_valid ? mem_rd[rd_ptr_q]       : '0;
  assign bus.out_rj_o        = head_valid ? mem_rj[rd_ptr_q]       : '0;
  assign bus.out_rk_o        = head_valid ? mem_rk[rd_ptr_q]       : '0;
  assign bus.out_inst_o      = head_valid ? mem_inst[rd_ptr_q]     : '0;
  assign bus.out_pc_o        = head_valid ? mem_pc[rd_ptr_q]       : '0;
endmodule

// File: tb/tb_op_predecode_stage.sv
// Self-checking bench for op_predecode_stage against a queue-based reference model.
module tb_op_predecode_stage;
  localparam int unsigned LANES = 2;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned OW    = 2 + CW + LANES * 277;

  typedef struct packed {
    logic [LANES-1:0]    mask;
    logic [32*LANES-1:0] inst;
    logic [32*LANES-1:0] pc;
  } beat_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  beat_t q[$];

  op_predecode_if #(.LANES(LANES), .BUF_DEPTH(DEPTH)) bus ();

  op_predecode_stage #(.LANES(LANES), .BUF_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [OW-1:0] dut_out();
    return {bus.out_valid_o, bus.in_ready_o, bus.count_o, bus.out_lane_mask_o,
            bus.out_op_31_26_o, bus.out_op_25_22_o, bus.out_op_21_20_o, bus.out_op_19_15_o,
            bus.out_rd_o, bus.out_rj_o, bus.out_rk_o, bus.out_inst_o, bus.out_pc_o};
  endfunction

  // Expected outputs: the head of the model queue, one-hot bits set by index.
  function automatic logic [OW-1:0] model_out();
    logic [LANES-1:0]    m;
    logic [64*LANES-1:0] o1;
    logic [16*LANES-1:0] o2;
    logic [4*LANES-1:0]  o3;
    logic [32*LANES-1:0] o4, rd, rj, rk, oi, op;
    logic [31:0]         ins;
    beat_t               e;
    m = '0; o1 = '0; o2 = '0; o3 = '0; o4 = '0;
    rd = '0; rj = '0; rk = '0; oi = '0; op = '0;
    if (q.size() != 0) begin
      e = q[0];
      m = e.mask;
      for (int l = 0; l < int'(LANES); l++) begin
        if (m[l]) begin
          ins = e.inst[32*l +: 32];
          o1[64*l + int'(ins[31:26])] = 1'b1;
          o2[16*l + int'(ins[25:22])] = 1'b1;
          o3[4*l  + int'(ins[21:20])] = 1'b1;
          o4[32*l + int'(ins[19:15])] = 1'b1;
          rd[32*l + int'(ins[4:0])]   = 1'b1;
          rj[32*l + int'(ins[9:5])]   = 1'b1;
          rk[32*l + int'(ins[14:10])] = 1'b1;
          oi[32*l +: 32] = ins;
          op[32*l +: 32] = e.pc[32*l +: 32];
        end
      end
    end
    return {q.size() != 0, q.size() != int'(DEPTH), CW'(q.size()), m,
            o1, o2, o3, o4, rd, rj, rk, oi, op};
  endfunction

  function automatic logic [32*LANES-1:0] rnd_word();
    logic [32*LANES-1:0] v;
    for (int l = 0; l < int'(LANES); l++) v[32*l +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive(input logic valid, input logic [LANES-1:0] mask,
                       input logic [32*LANES-1:0] inst, input logic [32*LANES-1:0] pc);
    bus.in_valid_i     = valid;
    bus.in_lane_mask_i = mask;
    bus.in_inst_i      = inst;
    bus.in_pc_i        = pc;
  endtask

  task automatic drive_rand(input logic valid);
    logic [LANES-1:0] m;
    m = LANES'($urandom_range(1, (1 << LANES) - 1));
    drive(valid, m, rnd_word(), rnd_word());
  endtask

  // Advance one clock and apply the spec's accept/pop/flush rules to the model.
  task automatic tick();
    logic  acc, pp, fl;
    beat_t b;
    fl  = bus.flush_i;
    acc = bus.in_valid_i && (q.size() != int'(DEPTH)) && !fl;
    pp  = (q.size() != 0) && bus.out_ready_i && !fl;
    b   = '{mask: bus.in_lane_mask_i, inst: bus.in_inst_i, pc: bus.in_pc_i};
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pp) q.delete(0);
      if (acc && b.mask != '0) q.push_back(b);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    drive(1'b0, '0, '0, '0);
    bus.out_ready_i = 1'b1;
    bus.flush_i     = 1'b0;
    repeat (DEPTH + 1) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.flush_i = 1'b0;
    bus.out_ready_i = 1'b0;
    drive(1'b1, '1, rnd_word(), rnd_word());
    q.delete();
    #1;
    checks++;
    if (dut_out() !== model_out()) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", dut_out(), model_out());
    end
    repeat (2) @(negedge clk);
    drive(1'b0, '0, '0, '0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_lane();
    logic [32*LANES-1:0] inst;
    inst = rnd_word();
    inst[31:0] = 32'h02800C21;
    inst[63:32] = inst[63:32] | 32'h1;
    bus.out_ready_i = 1'b0;
    drive(1'b1, 2'b01, inst, {32'h1C000004, 32'h1C000000});
    tick();
    drive(1'b0, '0, '0, '0);
    checks++;
    if (bus.out_op_31_26_o !== 128'h1 || bus.out_op_25_22_o !== 32'h400 ||
        bus.out_op_21_20_o !== 8'h01 || bus.out_op_19_15_o !== 64'h1) begin
      errors++;
      $display("FAIL single_lane_op got %h %h %h %h", bus.out_op_31_26_o,
               bus.out_op_25_22_o, bus.out_op_21_20_o, bus.out_op_19_15_o);
    end
    checks++;
    if (bus.out_rd_o !== 64'h2 || bus.out_rj_o !== 64'h2 || bus.out_rk_o !== 64'h8) begin
      errors++;
      $display("FAIL single_lane_regs got rd %h rj %h rk %h exp 2 2 8",
               bus.out_rd_o, bus.out_rj_o, bus.out_rk_o);
    end
    checks++;
    if (bus.out_pc_o !== 64'h1C000000 || bus.out_inst_o !== 64'h02800C21 ||
        bus.out_lane_mask_o !== 2'b01) begin
      errors++;
      $display("FAIL single_lane_pass got pc %h inst %h mask %b",
               bus.out_pc_o, bus.out_inst_o, bus.out_lane_mask_o);
    end
    checks++;
    if (dut_out() !== model_out()) begin
      errors++;
      $display("FAIL single_lane_model got %h exp %h", dut_out(), model_out());
    end
    drain();
  endtask

  task automatic test_fill_backpressure();
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1);
      tick();
    end
    checks++;
    if (bus.in_ready_o !== 1'b0 || bus.count_o !== CW'(2)) begin
      errors++;
      $display("FAIL fill_full got ready %b count %0d exp 0 2", bus.in_ready_o, bus.count_o);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL fill_hold got %h exp %h", dut_out(), model_out());
      end
      tick();
    end
    drive(1'b0, '0, '0, '0);
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL fill_drain got %h exp %h", dut_out(), model_out());
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int popped;
    int cycles;
    popped = 0;
    cycles = 0;
    bus.out_ready_i = 1'b1;
    for (int c = 0; c < 20 && popped < 8; c++) begin
      if (c < 8) drive(1'b1, '1, rnd_word(), {32'h1004 + 32'h100 * c, 32'h1000 + 32'h100 * c});
      else drive(1'b0, '0, '0, '0);
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL stream_model got %h exp %h", dut_out(), model_out());
      end
      if (bus.out_valid_o === 1'b1) begin
        checks++;
        if (bus.out_pc_o[31:0] !== 32'h1000 + 32'h100 * popped) begin
          errors++;
          $display("FAIL stream_order got %h exp %h", bus.out_pc_o[31:0],
                   32'h1000 + 32'h100 * popped);
        end
        popped++;
      end
      tick();
      cycles++;
    end
    checks++;
    if (popped != 8 || cycles != 9) begin
      errors++;
      $display("FAIL stream_rate got popped %0d cycles %0d exp 8 9", popped, cycles);
    end
    drain();
  endtask

  task automatic test_full_pop();
    bus.out_ready_i = 1'b0;
    repeat (2) begin
      drive_rand(1'b1);
      tick();
    end
    drive_rand(1'b1);
    bus.out_ready_i = 1'b1;
    checks++;
    if (bus.in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_ready got %b exp 0", bus.in_ready_o);
    end
    tick();
    checks++;
    if (bus.count_o !== CW'(1) || dut_out() !== model_out()) begin
      errors++;
      $display("FAIL fullpop_count got %h exp %h", dut_out(), model_out());
    end
    bus.out_ready_i = 1'b0;
    tick();
    checks++;
    if (bus.count_o !== CW'(2) || dut_out() !== model_out()) begin
      errors++;
      $display("FAIL fullpop_accept got %h exp %h", dut_out(), model_out());
    end
    drain();
  endtask

  task automatic test_flush();
    bus.out_ready_i = 1'b0;
    repeat (2) begin
      drive_rand(1'b1);
      tick();
    end
    drive(1'b1, '1, rnd_word(), {32'hDEAD0004, 32'hDEAD0000});
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    checks++;
    if (bus.count_o !== '0 || bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 ||
        dut_out() !== model_out()) begin
      errors++;
      $display("FAIL flush_clear got %h exp %h", dut_out(), model_out());
    end
    drive(1'b1, '1, rnd_word(), {32'h2004, 32'h2000});
    tick();
    drive(1'b0, '0, '0, '0);
    checks++;
    if (bus.count_o !== CW'(1) || bus.out_pc_o[31:0] !== 32'h2000) begin
      errors++;
      $display("FAIL flush_after got count %0d pc %h exp 1 2000", bus.count_o, bus.out_pc_o[31:0]);
    end
    drain();
  endtask

  task automatic test_zero_mask();
    bus.out_ready_i = 1'b0;
    drive_rand(1'b1);
    tick();
    drive(1'b1, '0, rnd_word(), rnd_word());
    checks++;
    if (bus.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL zero_mask_ready got %b exp 1", bus.in_ready_o);
    end
    tick();
    drive(1'b0, '0, '0, '0);
    checks++;
    if (bus.count_o !== CW'(1) || dut_out() !== model_out()) begin
      errors++;
      $display("FAIL zero_mask_count got %h exp %h", dut_out(), model_out());
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    bus.out_ready_i = 1'b0;
    repeat (2) begin
      drive_rand(1'b1);
      tick();
    end
    drive(1'b0, '0, '0, '0);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.count_o !== '0 || dut_out() !== model_out()) begin
      errors++;
      $display("FAIL reset_mid got %h exp %h", dut_out(), model_out());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom % 10) < 7, LANES'($urandom), rnd_word(), rnd_word());
      bus.out_ready_i = ($urandom % 10) < 6;
      bus.flush_i     = ($urandom % 16) == 0;
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL random_c%0d got %h exp %h", c, dut_out(), model_out());
      end
      tick();
    end
    bus.flush_i = 1'b0;
    drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_lane();
    test_fill_backpressure();
    test_back_to_back();
    test_full_pop();
    test_flush();
    test_zero_mask();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
